// File: rtl/rom_fetch_pkg.sv
// Shared definitions for the instruction ROM fetch initiator:
// FSM state encodings, FIFO geometry, synchronizer depth and the FIFO entry layout.
package rom_fetch_pkg;

    localparam int SYNC_DEPTH = 2;
    localparam int FIFO_DEPTH = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_POLL  = 2'd3;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/rom_fetch_sync2.sv
// Two-flop synchronizer bringing the ROM ready line into the clk domain.
// Clears to 0 on reset so a stale ready cannot be seen right after reset.
module sync2
    import rom_fetch_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] sr;

    // shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = sr[SYNC_DEPTH-1];

endmodule

// File: rtl/rom_fetch.sv
// Fetch initiator for the word-addressed instruction ROM. Issues two-phase
// (toggle) requests, waits out the synchronizer latency, captures the word on
// synchronized ready and buffers {instr, pc} in a 2-entry FIFO for decode.
// Optional build macro: ROM_FETCH_TIMEOUT_EN adds a POLL timeout with a sticky
// errorOut; without it POLL waits indefinitely and errorOut is tied low.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no request in flight; issue when FIFO has space and no error
// ISSUE    | latch address, toggle trigger, record request pc, advance pc
// WAIT     | MIN_WAIT cycles ignoring ready (stale ready may still be high)
// POLL     | wait for synchronized ready, push word unless discarded
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MIN_WAIT = 3,
    parameter int          TIMEOUT  = 255
)
(
    input  logic        clk,
    input  logic        resetN,
    output logic [31:0] romAddrOut,
    output logic        romTriggerOut,
    input  logic        romReadyIn,
    input  logic [31:0] romDataIn,
    input  logic        branchIn,
    input  logic [31:0] branchTargetIn,
    output logic [31:0] instrOut,
    output logic [31:0] pcOut,
    output logic        instrValidOut,
    input  logic        instrReadyIn,
    output logic        errorOut
);

    // one down-counter serves both the WAIT window and the POLL timeout
    localparam int TMR_MAX = (TIMEOUT > MIN_WAIT) ? TIMEOUT : MIN_WAIT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    logic [1:0]       state;
    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic             discard;
    logic [TMR_W-1:0] tmr;
    logic             rdy_sync;
    logic             err;
    logic             tmo_hit;
    logic             poll_done;

    fifo_entry_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    sync2 u_sync (
        .clk    (clk),
        .resetN (resetN),
        .d      (romReadyIn),
        .q      (rdy_sync)
    );

`ifdef ROM_FETCH_TIMEOUT_EN
    assign tmo_hit = (state == ST_POLL) && !rdy_sync && (tmr == '0);

    // sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            err <= 1'b0;
        end else if (tmo_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign errorOut = err;

    // handshake outcome and FIFO strobes; a branch flush overrides push and pop
    always_comb begin
        poll_done     = (state == ST_POLL) && (rdy_sync || tmo_hit);
        instrValidOut = (count != 2'd0);
        pop           = instrValidOut && instrReadyIn && !branchIn;
        push          = (state == ST_POLL) && rdy_sync && !discard && !branchIn;
        instrOut      = mem[rptr].instr;
        pcOut         = mem[rptr].pc;
    end

    // request FSM, pc tracking and branch redirect
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            req_pc        <= '0;
            romAddrOut    <= {2'b00, RESET_PC[31:2]};
            romTriggerOut <= 1'b0;
            discard       <= 1'b0;
            tmr           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((count < 2'(FIFO_DEPTH)) && !err) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    romAddrOut    <= {2'b00, pc[31:2]};
                    romTriggerOut <= ~romTriggerOut;
                    req_pc        <= pc;
                    pc            <= pc + 32'd4;
                    tmr           <= TMR_W'(MIN_WAIT - 1);
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tmr == '0) begin
                        state <= ST_POLL;
`ifdef ROM_FETCH_TIMEOUT_EN
                        tmr   <= TMR_W'(TIMEOUT - 1);
`endif
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_POLL: begin
                    if (rdy_sync) begin
                        state   <= ST_IDLE;
                        discard <= 1'b0;
                    end
`ifdef ROM_FETCH_TIMEOUT_EN
                    else if (tmr == '0) begin
                        state   <= ST_IDLE;
                        discard <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase

            // an issued transition cannot be recalled: let it finish and drop its word
            if (branchIn) begin
                pc <= branchTargetIn & ~32'h3;
                if ((state != ST_IDLE) && !poll_done) begin
                    discard <= 1'b1;
                end
            end
        end
    end

    // 2-entry circular FIFO toward decode; branch flushes it
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (branchIn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= '{instr: romDataIn, pc: req_pc};
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch.sv
// Scoreboard bench for rom_fetch: stimulus pushes expected {instr, pc} words,
// a monitor pops and compares on every accepted transfer. A behavioural ROM
// answers each trigger toggle after ROM_LAT cycles.
module tb_rom_fetch;

    localparam int MIN_WAIT = 3;
    localparam int TIMEOUT  = 255;
    localparam int ROM_LAT  = 6;

    logic        clk = 1'b0;
    logic        resetN;
    logic [31:0] romAddrOut;
    logic        romTriggerOut;
    logic        romReadyIn;
    logic [31:0] romDataIn;
    logic        branchIn;
    logic [31:0] branchTargetIn;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic        instrValidOut;
    logic        instrReadyIn;
    logic        errorOut;

    rom_fetch #(
        .RESET_PC (32'h0000_0000),
        .MIN_WAIT (MIN_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .romAddrOut     (romAddrOut),
        .romTriggerOut  (romTriggerOut),
        .romReadyIn     (romReadyIn),
        .romDataIn      (romDataIn),
        .branchIn       (branchIn),
        .branchTargetIn (branchTargetIn),
        .instrOut       (instrOut),
        .pcOut          (pcOut),
        .instrValidOut  (instrValidOut),
        .instrReadyIn   (instrReadyIn),
        .errorOut       (errorOut)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'd0) return 32'hE3A0_0005;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_run(input logic [31:0] pc0, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{instr: rom_word((pc0 + 32'(4 * i)) >> 2), pc: pc0 + 32'(4 * i)});
        end
    endtask

    // behavioural ROM: each trigger transition restarts the response timer
    logic rom_last = 1'b0;
    int   rom_cnt  = 0;
    logic [31:0] rom_addr = '0;
    bit   rom_dead = 1'b0;
    initial begin
        romReadyIn = 1'b0;
        romDataIn  = 32'hDEAD_BEEF;
    end
    always @(negedge clk) begin
        if (romTriggerOut !== rom_last) begin
            rom_last   = romTriggerOut;
            rom_addr   = romAddrOut;
            romReadyIn = 1'b0;
            romDataIn  = 32'hDEAD_BEEF;
            rom_cnt    = ROM_LAT;
        end else if (rom_cnt > 0) begin
            rom_cnt--;
            if (rom_cnt == 0 && !rom_dead) begin
                romDataIn  = rom_word(rom_addr);
                romReadyIn = 1'b1;
            end
        end
    end

    // trigger transition counter, with the cycle on which each was seen
    logic trig_prev = 1'b0;
    int   toggles   = 0;
    int   tog_cyc   = 0;
    always @(negedge clk) begin
        if (romTriggerOut !== trig_prev) begin
            trig_prev = romTriggerOut;
            toggles++;
            tog_cyc = cyc;
        end
    end

    // scoreboard monitor: every accepted head must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (resetN && instrValidOut && instrReadyIn && !branchIn) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got instr %h pc %h expected none", instrOut, pcOut);
            end else begin
                e = exp_q.pop_front();
                check32("sb_instr", instrOut, e.instr);
                check32("sb_pc", pcOut, e.pc);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_toggle(input string name);
        int  t0;
        bit  ok;
        t0 = toggles;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (toggles != t0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got no trigger toggle expected one within 60 cycles", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int err_cyc;
        instrReadyIn   = 1'b0;
        branchIn       = 1'b0;
        branchTargetIn = '0;
        resetN         = 1'b1;
        #2 resetN = 1'b0;
        cycles(3);

        check32("rst_trigger", 32'(romTriggerOut), 32'd0);
        check32("rst_addr", romAddrOut, 32'd0);
        check32("rst_valid", 32'(instrValidOut), 32'd0);
        check32("rst_instr", instrOut, 32'd0);
        check32("rst_pc", pcOut, 32'd0);
        check32("rst_error", 32'(errorOut), 32'd0);

        // stalled decode: exactly two words, then one more fetch per freed slot
        push_run(32'h0, 3);
        resetN = 1'b1;
        cycles(60);
        check32("stall_toggles", 32'(toggles), 32'd2);
        check32("stall_addr", romAddrOut, 32'd1);
        check32("stall_valid", 32'(instrValidOut), 32'd1);
        check32("first_instr", instrOut, 32'hE3A0_0005);
        check32("first_pc", pcOut, 32'd0);
        instrReadyIn = 1'b1;
        cycles(1);
        instrReadyIn = 1'b0;
        cycles(40);
        check32("refill_toggles", 32'(toggles), 32'd3);
        check32("refill_addr", romAddrOut, 32'd2);
        check32("refill_head_pc", pcOut, 32'd4);

        // branch while the request to word 3 sits in WAIT
        instrReadyIn = 1'b1;
        cycles(1);
        instrReadyIn = 1'b0;
        wait_toggle("wait_issue");
        check32("inflight_addr", romAddrOut, 32'd3);
        branchIn       = 1'b1;
        branchTargetIn = 32'h0000_0103;
        exp_q.delete();
        push_run(32'h100, 2);
        cycles(1);
        branchIn = 1'b0;
        check32("br_wait_valid", 32'(instrValidOut), 32'd0);
        cycles(60);
        check32("br_wait_toggles", 32'(toggles), 32'd6);
        check32("br_wait_addr", romAddrOut, 32'h41);
        check32("br_wait_pc", pcOut, 32'h100);
        check32("br_wait_instr", instrOut, rom_word(32'h40));

        // branch coincident with a pop at FIFO count 2
        instrReadyIn   = 1'b1;
        branchIn       = 1'b1;
        branchTargetIn = 32'h0000_0200;
        exp_q.delete();
        push_run(32'h200, 20);
        cycles(1);
        branchIn     = 1'b0;
        instrReadyIn = 1'b0;
        check32("br_pop_valid", 32'(instrValidOut), 32'd0);
        cycles(60);
        check32("br_pop_toggles", 32'(toggles), 32'd8);
        check32("br_pop_addr", romAddrOut, 32'h81);
        check32("br_pop_pc", pcOut, 32'h200);
        instrReadyIn = 1'b1;
        cycles(40);

        // reset pulse while a request is in POLL
        wait_toggle("poll_issue");
        cycles(2);
        #2 resetN = 1'b0;
        #1;
        check32("poll_rst_trigger", 32'(romTriggerOut), 32'd0);
        check32("poll_rst_addr", romAddrOut, 32'd0);
        check32("poll_rst_valid", 32'(instrValidOut), 32'd0);
        check32("poll_rst_instr", instrOut, 32'd0);
        check32("poll_rst_pc", pcOut, 32'd0);
        exp_q.delete();
        push_run(32'h0, 20);
        instrReadyIn = 1'b0;
        cycles(2);
        resetN = 1'b1;
        @(negedge clk);
        t0 = toggles;
        cycles(60);
        check32("restart_toggles", 32'(toggles - t0), 32'd2);
        check32("restart_addr", romAddrOut, 32'd1);
        check32("restart_pc", pcOut, 32'd0);
        check32("restart_instr", instrOut, 32'hE3A0_0005);
        instrReadyIn = 1'b1;
        cycles(20);
        instrReadyIn = 1'b0;
        cycles(60);

        // dead ROM: a request that never sees ready
        rom_dead       = 1'b1;
        t0             = toggles;
        branchIn       = 1'b1;
        branchTargetIn = 32'h0000_0300;
        exp_q.delete();
        cycles(1);
        branchIn = 1'b0;
        wait_toggle("dead_issue");
        check32("dead_addr", romAddrOut, 32'hC0);
`ifdef ROM_FETCH_TIMEOUT_EN
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (errorOut) break;
        end
        err_cyc = cyc;
        check32("timeout_error", 32'(errorOut), 32'd1);
        // the ISSUE cycle starts one edge before the toggle is seen
        check32("timeout_latency", 32'(err_cyc - (tog_cyc - 1)), 32'(TIMEOUT + MIN_WAIT + 1));
        t0 = toggles;
        cycles(30);
        check32("timeout_no_toggle", 32'(toggles - t0), 32'd0);
        check32("timeout_sticky", 32'(errorOut), 32'd1);
`else
        err_cyc = 0;
        cycles(300);
        check32("no_timeout_error", 32'(errorOut), 32'd0);
        check32("no_timeout_toggles", 32'(toggles - t0), 32'd1);
        check32("no_timeout_cyc", 32'(err_cyc), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_fetch.md
# rom_fetch

Clocked fetch initiator for the word-addressed instruction ROM. It drives the ROM's two-phase (transition-signalled) request, waits for the ROM's ready, captures the returned word, and buffers it for decode through a 2-entry valid/ready FIFO. It sits between the PC/branch logic and decode, and is the only master of the ROM `addr`/`triggerIn` pair.

## Interface
- `RESET_PC`, 32'h0000_0000: byte address of the first fetch after reset.
- `MIN_WAIT`, 3: cycles after a trigger toggle during which ROM ready is ignored. Must be ≥ synchronizer depth (2) + 1.
- `TIMEOUT`, 255: poll cycles before a request is declared dead (only with `ROM_FETCH_TIMEOUT_EN`).
- `clk`  in  1: single clock, rising edge.
- `resetN`  in  1: asynchronous, active-low reset.
- `romAddrOut`  out  32: ROM word address, equal to `pc[31:2]` zero-extended.
- `romTriggerOut`  out  1: request line; each toggle (either edge) is one request.
- `romReadyIn`  in  1: ROM ready, asynchronous to `clk`.
- `romDataIn`  in  32: ROM read data; stable while `romReadyIn`=1.
- `branchIn`  in  1: redirect strobe, one cycle.
- `branchTargetIn`  in  32: byte target; bits [1:0] ignored.
- `instrOut`  out  32: head-of-FIFO instruction.
- `pcOut`  out  32: byte PC of `instrOut`.
- `instrValidOut`  out  1: FIFO not empty.
- `instrReadyIn`  in  1: decode accepts head when valid.
- `errorOut`  out  1: sticky timeout flag.

## Operation
- State machine: IDLE → ISSUE → WAIT → POLL → IDLE.
- IDLE: go to ISSUE when FIFO count + outstanding < 2 and `errorOut`=0.
- ISSUE (1 cycle): latch `romAddrOut`=`pc>>2`, toggle `romTriggerOut`, record `reqPc`=pc, set pc=pc+4.
- WAIT: count `MIN_WAIT` cycles, ignoring the ready input.
- POLL: when synchronized ready=1, push {`romDataIn`, `reqPc`} unless `discard` is set, clear `discard`, and go to IDLE. `romDataIn` is sampled directly; it is stable because ready is high.
- Branch: pc=`branchTargetIn` & ~3, and the FIFO is flushed the same edge. If the state is WAIT or POLL, set `discard`. An in-flight transition cannot be withdrawn, so the handshake must complete and its word is dropped.
- Branch and ISSUE in the same cycle: the issued request is treated as stale (`discard` set) and the next ISSUE uses the target.
- Push and pop in the same cycle with FIFO full is impossible, because issue is gated by space. Push plus pop at count 1 leaves count at 1.
- Branch together with pop: the flush wins and the pop is ignored.
- FIFO: 2 entries, circular read/write pointers, 2-bit count.

## Timing
- Reset values: `romTriggerOut`=0, `romAddrOut`=`RESET_PC>>2`, pc=`RESET_PC`, FIFO empty, `instrValidOut`=0, `instrOut`=0, `pcOut`=0, `errorOut`=0, state IDLE, `discard`=0.
- `resetN` asserted mid-handshake: everything returns to reset immediately. The ROM sees at most one extra transition, which the team accepts.
- Latency: ISSUE edge to push edge is ≥ `MIN_WAIT`+1 cycles. `instrValidOut` rises the cycle after the push.
- Best-case throughput: one word per `MIN_WAIT`+3 cycles.
- Pop: head advances on the edge where `instrValidOut`&&`instrReadyIn`.
- Branch: `instrValidOut`=0 the cycle after `branchIn`.

## Configuration
- `ROM_FETCH_TIMEOUT_EN` defined: POLL counts cycles. After `TIMEOUT` cycles, `errorOut`=1 (sticky until reset) and the FSM parks in IDLE.
- Macro undefined: no counter, POLL waits forever, and `errorOut` is tied 0.

## Structure
- Package `rom_fetch_pkg`: the FSM state enum (IDLE/ISSUE/WAIT/POLL), the `FIFO_DEPTH`=2 constant, and the synchronizer depth constant.
- Sub-module `sync2`: a 2-flop synchronizer for `romReadyIn`, reset to 0.

## Test plan
- Reset release with `RESET_PC`=0 and a ROM model holding mem[0]=32'hE3A00005 → first ISSUE toggles trigger 0→1 with addr 0; `instrOut`=E3A00005, `pcOut`=0.
- Decode stalled (`instrReadyIn`=0) → exactly 2 words buffered (pc 0, 4), no third toggle; releasing ready for 1 cycle triggers one more fetch at addr 2.
- `branchIn` with target 32'h0000_0103 during WAIT → the in-flight word is dropped, the next address is 32'h40, and `pcOut`=32'h100.
- Branch coincident with a pop at FIFO count 2 → `instrValidOut`=0 the next cycle and no stale word ever appears.
- `resetN` pulsed low during POLL → outputs return to reset values asynchronously; after release, fetching restarts at `RESET_PC`.
- With `ROM_FETCH_TIMEOUT_EN` defined and the ROM ready held 0 → `errorOut`=1 after `TIMEOUT`+`MIN_WAIT`+1 cycles, with no further toggles.
